// File: rtl/level_triggered_data_receiver.sv
// level_triggered_data_receiver: receive end of the sclk/sda serial link.
// Oversamples sclk/sda on clk, shifts sda in MSB first on each sclk rise,
// and hands completed DATA_W-bit words to a valid/ready consumer.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   sclk, sda       serial clock/data from the transmitter (async to clk)
//   rx_data         last completed word
//   rx_valid        rx_data holds an unconsumed word
//   rx_ready        consumer accepts the word
//   busy            a word is partially received
//   overrun         sticky: a completed word was dropped
//   ovr_clr         clears overrun (a same-cycle set wins)
//   frame_err       one-cycle pulse when a partial word times out
//
// Optional build macro: LEVEL_TRIGGER_RX_DEGLITCH_EN
//   When defined, an sclk edge is accepted only after s_sclk has held its
//   new level for DEGLITCH_LEN consecutive clk cycles.

module level_triggered_data_receiver #(
  parameter int DATA_W       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 255,
  parameter int DEGLITCH_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sda,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Synchronisers

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   s_sclk;
  logic                   s_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      sda_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_sda  = sda_sync[SYNC_STAGES-1];

  // Edge detection

  logic prev_sclk;
  logic rise;
  logic fall;

`ifdef LEVEL_TRIGGER_RX_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH_LEN + 1);

  // prev_sclk is the last accepted sclk level; dg_cnt counts how long
  // s_sclk has disagreed with it. A disagreement that ends early resets
  // the count, so short pulses never become edges.
  logic [DG_W-1:0] dg_cnt;
  logic            dg_hit;

  assign dg_hit = (s_sclk != prev_sclk) &&
                  (dg_cnt == DG_W'(DEGLITCH_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sclk <= 1'b0;
      dg_cnt    <= '0;
    end else begin
      if (s_sclk == prev_sclk || dg_hit) begin
        dg_cnt <= '0;
      end else begin
        dg_cnt <= dg_cnt + DG_W'(1);
      end
      if (dg_hit) begin
        prev_sclk <= s_sclk;
      end
    end
  end

  assign rise = dg_hit && s_sclk;
  assign fall = dg_hit && !s_sclk;
`else
  // DEGLITCH_LEN has no effect in this build.
  logic unused_deglitch_len;
  assign unused_deglitch_len = ^DEGLITCH_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sclk <= 1'b0;
    end else begin
      prev_sclk <= s_sclk;
    end
  end

  assign rise = s_sclk && !prev_sclk;
  assign fall = !s_sclk && prev_sclk;
`endif

  // Receive state machine

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [IDL_W-1:0]  idle_cnt;
  logic [IDL_W-1:0]  idle_d;
  logic              done_q;
  logic              done_d;
  logic              ferr_d;
  logic              timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      idle_cnt <= '0;
      done_q   <= 1'b0;
      frame_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_cnt  <= cnt_d;
      shift_q  <= shift_d;
      idle_cnt <= idle_d;
      done_q   <= done_d;
      frame_err <= ferr_d;
      busy     <= (cnt_d != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_cnt;
    shift_d = shift_q;
    idle_d  = idle_cnt;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    if (rise || fall) begin
      idle_d = '0;
    end else if (idle_cnt != IDL_W'(IDLE_TIMEOUT)) begin
      idle_d = idle_cnt + IDL_W'(1);
    end

    // The cycle the counter steps onto IDLE_TIMEOUT; any edge in the
    // same cycle wins and suppresses the timeout.
    timeout = !rise && !fall &&
              (idle_cnt == IDL_W'(IDLE_TIMEOUT - 1));

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          shift_d = {shift_q[DATA_W-2:0], s_sda};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shift_d = {shift_q[DATA_W-2:0], s_sda};
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = bit_cnt + CNT_W'(1);
          end
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
    endcase
  end

  // Output word, handshake and overrun

  logic ovr_set;

  // A completed word is dropped only if the held word is not being
  // consumed in the same cycle.
  assign ovr_set = done_q && rx_valid && !rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (done_q && !ovr_set) begin
      rx_data  <= shift_q;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/level_triggered_data_receiver.md
Name: level_triggered_data_receiver

Overview:
- Receive end of the two-wire sclk/sda serial link.
- The transmitter drives sda while sclk is low, MSB first, and holds sda stable while sclk is high.
- This block runs on the fast system clock and oversamples sclk and sda.
- It captures sda on each sclk rising edge, assembles DATA_W-bit words and presents them on a valid/ready output with overrun and frame-error reporting.

Parameters:
- DATA_W, 8, bits per word; serial order is MSB first.
- SYNC_STAGES, 2, synchroniser flops on sclk and sda; minimum 2.
- IDLE_TIMEOUT, 255, clk cycles without any sclk edge before a partial word is abandoned; minimum 2.
- DEGLITCH_LEN, 3, clk cycles sclk must be stable before an edge is accepted; used only with the optional feature.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- sclk, input, 1, serial clock from the transmitter; asynchronous to clk.
- sda, input, 1, serial data from the transmitter; asynchronous to clk.
- rx_data, output, DATA_W, last completed word.
- rx_valid, output, 1, rx_data holds an unconsumed word.
- rx_ready, input, 1, consumer accepts the word.
- busy, output, 1, a word is partially received (bit count is nonzero).
- overrun, output, 1, sticky flag: a word was dropped.
- ovr_clr, input, 1, clears overrun.
- frame_err, output, 1, one-cycle pulse when a partial word is abandoned on timeout.

Behaviour:
- Reset values, asynchronous:
  - Synchroniser flops, previous-sclk register, shift register, bit count and idle counter are 0.
  - rx_data = 0, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0.
- Reset asserted mid-word discards the partial word; reception restarts cleanly on the first rising edge after release.
- Synchronisation: sclk and sda each pass through SYNC_STAGES flops (s_sclk, s_sda).
- Edge detection: a rising edge is s_sclk = 1 while the previous s_sclk = 0. A falling edge is the inverse.
- Edge latency: an edge is detected SYNC_STAGES+1 clk cycles after the pin transition.
- State machine: IDLE (bit count 0) and SHIFT (bit count 1..DATA_W-1).
  - IDLE -> SHIFT on the first rising edge.
  - SHIFT -> IDLE on word completion or on timeout.
- Rising edge in either state:
  - Shift register becomes {shift[DATA_W-2:0], s_sda}.
  - Bit count increments.
  - Falling edges only reset the idle counter.
- Word completion, on the DATA_W-th rising edge:
  - Bit count wraps to 0.
  - On the next clk edge the complete word loads into rx_data and rx_valid = 1, unless an overrun occurs.
- Handshake:
  - rx_valid stays high with rx_data stable until the cycle where rx_valid and rx_ready are both 1.
  - rx_valid clears on the clk edge ending that cycle.
  - rx_ready while rx_valid = 0 has no effect.
- Simultaneous handshake and completion: the new word loads and rx_valid stays 1. This is not an overrun.
- Overrun:
  - Condition: a word completes while rx_valid = 1 and rx_ready = 0.
  - The new word is dropped, rx_data keeps the old word, and overrun is set.
  - overrun clears on ovr_clr.
  - If set and ovr_clr are requested in the same cycle, set wins.
- Idle counter:
  - Cleared on any accepted sclk edge; otherwise increments and saturates at IDLE_TIMEOUT.
  - Reaching IDLE_TIMEOUT with bit count nonzero: bit count clears, state goes to IDLE, frame_err pulses for 1 cycle.
  - Reaching IDLE_TIMEOUT in IDLE gives no pulse.
  - An edge arriving in the same cycle as the timeout wins, and no frame_err is raised.
- busy = (bit count != 0), driven from a register.
- Input rate: sclk half-periods shorter than SYNC_STAGES+2 clk cycles are out of spec and bits may be lost. No other requirement applies to such inputs.

Optional Feature:
- Macro: LEVEL_TRIGGER_RX_DEGLITCH_EN.
- When defined:
  - An edge is accepted only after s_sclk has held its new level for DEGLITCH_LEN consecutive clk cycles.
  - Pulses shorter than that are ignored, with no shift and no idle-counter clear.
  - Edge latency grows by DEGLITCH_LEN-1 cycles.
- When undefined: DEGLITCH_LEN is ignored, edges are accepted as described above, and no deglitch logic exists.

Test Plan:
- Transmitter stimulus: sclk toggles every 51 clk cycles, sda = 0xAD MSB first, rx_ready held at 1.
  - Required: rx_valid pulses once per word with rx_data = 0xAD.
  - Required: busy rises after the first rising edge; overrun stays 0.
- Back-pressure: send 0xAD then 0x5A with rx_ready = 0.
  - Required: rx_data = 0xAD, rx_valid = 1, overrun = 1.
  - Then assert ovr_clr: overrun returns to 0.
- Handshake race: assert rx_ready in the exact cycle the second word completes.
  - Required: rx_data changes from 0xAD to 0x5A, rx_valid stays 1, overrun stays 0.
- Timeout: send 3 bits, then hold sclk low for 300 cycles.
  - Required: one frame_err pulse 255 cycles after the last edge and busy returns to 0.
  - The next full word 0xC3 is received correctly.
- Reset mid-word: assert rst after 5 bits.
  - Required: all outputs are 0 immediately.
  - After release, a full 0x96 is received with no stale bits.
- With LEVEL_TRIGGER_RX_DEGLITCH_EN: inject 1-cycle sclk high glitches between real edges while sending 0xAD.
  - Required: rx_data = 0xAD.
  - Without the macro, the same stimulus corrupts the word.
